jaa_sequencer: RTL and testbench

Fetch/decode/issue controller for the Java-to-ARM translator. It walks a bytecode program held in a synchronous-read byte memory and collects the operand bytes each opcode needs. It then issues the resulting ARM instruction words, one per cycle, over a valid/ready stream to the result writer. It replaces the free-running byte reader with an addressed, stallable, start/done-controlled sequence.

---
 rtl/jaa_sequencer.sv | 179 +++++++++++++++++
 tb/tb_jaa_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/jaa_sequencer.sv
// Fetch/decode/issue controller for the Java-to-ARM translator: reads bytecode
// through a synchronous byte memory and streams the ARM words for each opcode.
module jaa_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_pc
);

  typedef enum logic [2:0] {
    IDLE, FETCH_OP, DECODE, FETCH_ARG, LATCH_ARG, EMIT, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [31:0] PUSH_R1 = 32'hE92D0002;
  localparam logic [31:0] POP_R1  = 32'hE8BD0002;
  localparam logic [31:0] POP_R12 = 32'hE8BD0006;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] len, len_next;
  logic [7:0]        opcode, opcode_next;
  logic [7:0]        imm, imm_next;
  logic [1:0]        idx, idx_next;
  logic              error_reg, error_next;
  logic [ADDR_W-1:0] err_pc_reg, err_pc_next;

  // In DECODE the opcode register is not yet loaded, so classify the live read data.
  logic [7:0]  op_sel;
  logic [7:0]  op_lo;
  logic        op_known;
  logic        op_bipush;
  logic [1:0]  last_idx;
  logic [31:0] word;

  assign op_sel = (state == DECODE) ? mem_data : opcode;

  always_comb begin
    op_known  = 1'b1;
    op_bipush = 1'b0;
    last_idx  = 2'd1;
    word      = 32'h0;
    op_lo     = 8'h0;
    if (op_sel >= 8'h03 && op_sel <= 8'h08) begin
      op_lo = op_sel - 8'h03;
      word  = (idx == 2'd0) ? (32'hE3A01000 | {24'h0, op_lo}) : PUSH_R1;
    end else if (op_sel >= 8'h3B && op_sel <= 8'h3E) begin
      op_lo = op_sel - 8'h3B;
      word  = (idx == 2'd0) ? POP_R1 : (32'hE5813000 | {24'h0, op_lo});
    end else if (op_sel >= 8'h1A && op_sel <= 8'h1D) begin
      op_lo = op_sel - 8'h1A;
      word  = (idx == 2'd0) ? (32'hE5913000 | {24'h0, op_lo}) : PUSH_R1;
    end else if (op_sel == 8'h60 || op_sel == 8'h64) begin
      last_idx = 2'd2;
      case (idx)
        2'd0:    word = POP_R12;
        2'd1:    word = (op_sel == 8'h60) ? 32'hE0821001 : 32'hE0421001;
        default: word = PUSH_R1;
      endcase
    end else if (op_sel == 8'h10) begin
      op_bipush = 1'b1;
      // Operand is placed raw (zero-extended), matching the original translator.
      word = (idx == 2'd0) ? (32'hE3A01000 | {24'h0, imm}) : PUSH_R1;
    end else begin
      op_known = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      len        <= '0;
      opcode     <= 8'h0;
      imm        <= 8'h0;
      idx        <= 2'd0;
      error_reg  <= 1'b0;
      err_pc_reg <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      len        <= len_next;
      opcode     <= opcode_next;
      imm        <= imm_next;
      idx        <= idx_next;
      error_reg  <= error_next;
      err_pc_reg <= err_pc_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    len_next    = len;
    opcode_next = opcode;
    imm_next    = imm;
    idx_next    = idx;
    error_next  = error_reg;
    err_pc_next = err_pc_reg;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    out_valid   = 1'b0;
    out_word    = 32'h0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          len_next   = prog_len;
          pc_next    = '0;
          error_next = 1'b0;
          state_next = (prog_len == '0) ? FINISH : FETCH_OP;
        end
      end
      FETCH_OP: begin
        mem_rd     = 1'b1;
        mem_addr   = pc;
        pc_next    = pc + ONE;
        state_next = DECODE;
      end
      DECODE: begin
        opcode_next = mem_data;
        idx_next    = 2'd0;
        if (!op_known || (op_bipush && pc == len)) begin
          error_next  = 1'b1;
          err_pc_next = pc - ONE;
          state_next  = IDLE;
        end else if (op_bipush) begin
          state_next = FETCH_ARG;
        end else begin
          state_next = EMIT;
        end
      end
      FETCH_ARG: begin
        mem_rd     = 1'b1;
        mem_addr   = pc;
        pc_next    = pc + ONE;
        state_next = LATCH_ARG;
      end
      LATCH_ARG: begin
        imm_next   = mem_data;
        state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_word  = word;
        if (out_ready) begin
          if (idx == last_idx) begin
            idx_next   = 2'd0;
            state_next = (pc == len) ? FINISH : FETCH_OP;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state != IDLE) && (state != FINISH);
  assign error  = error_reg;
  assign err_pc = err_pc_reg;

endmodule

// File: tb/tb_jaa_sequencer.sv
// Directed bench for jaa_sequencer: byte memory model, word stream and
// status checks with hand-computed expectations.
module tb_jaa_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  prog_len = 8'h0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data = 8'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  err_pc;

  int total = 0;
  int bad = 0;
  logic [7:0]  mem [256];
  logic [31:0] exp_q [$];

  jaa_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .busy(busy), .done(done), .error(error), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
  endtask

  // Starts a program, checks every accepted word against exp_q, and the final status.
  // rst_word >= 0 asserts reset while that word index is presented, then returns.
  task automatic run_prog(input string name, input int len, input bit stall, input int rst_word,
                          input bit exp_err, input logic [7:0] exp_pc, input int exp_rd,
                          input int exp_first);
    int nw = 0, n_done = 0, n_rd = 0, rd_late = 0, first = -1, tail = -1;
    bit held = 1'b0, ended = 1'b0;
    logic [31:0] held_w = 32'h0;
    logic [7:0]  pat = 8'b1001_0110;
    @(negedge clk);
    prog_len = len[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      out_ready = stall ? pat[cyc % 8] : 1'b1;
      if (held) begin
        chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
        chk({name, " hold_word"}, out_word, held_w);
      end
      if (mem_rd) begin
        if (ended) rd_late++;
        else n_rd++;
      end
      if (out_valid && rst_word >= 0 && nw == rst_word) begin
        chk({name, " pre_reset_word"}, out_word, exp_q[nw]);
        reset = 1'b1;
        #1;
        chk({name, " rst_valid"}, 32'(out_valid), 32'd0);
        chk({name, " rst_word"}, out_word, 32'd0);
        chk({name, " rst_busy"}, 32'(busy), 32'd0);
        chk({name, " rst_mem_rd"}, {23'd0, mem_rd, mem_addr}, 32'd0);
        chk({name, " rst_status"}, {22'd0, done, error, err_pc}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (out_valid && out_ready) begin
        if (nw == 0) first = cyc;
        chk($sformatf("%s word%0d", name, nw), out_word,
            (nw < exp_q.size()) ? exp_q[nw] : 32'hDEAD_BEEF);
        nw++;
      end
      held   = out_valid && !out_ready;
      held_w = out_word;
      if (done) n_done++;
      if (!ended && (done || error)) begin
        ended = 1'b1;
        tail  = cyc + 4;
      end
      if (cyc == tail) break;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({name, " ended"}, 32'(ended), 32'd1);
    chk({name, " word_count"}, 32'(nw), 32'(exp_q.size()));
    chk({name, " done_count"}, 32'(n_done), exp_err ? 32'd0 : 32'd1);
    chk({name, " error"}, 32'(error), 32'(exp_err));
    if (exp_err) chk({name, " err_pc"}, 32'(err_pc), 32'(exp_pc));
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    chk({name, " reads"}, 32'(n_rd), 32'(exp_rd));
    chk({name, " late_reads"}, 32'(rd_late), 32'd0);
    if (exp_first >= 0) chk({name, " first_latency"}, 32'(first), 32'(exp_first));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_word", out_word, 32'd0);
    chk("reset mem_rd", 32'(mem_rd), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    chk("reset err_pc", 32'(err_pc), 32'd0);
    reset = 1'b0;

    // iconst_1, istore_1
    load(8'h04, 8'h3C, 8'h00, 8'h00);
    exp_q = '{32'hE3A01001, 32'hE92D0002, 32'hE8BD0002, 32'hE5813001};
    run_prog("p1", 2, 1'b0, -1, 1'b0, 8'h0, 2, 3);

    // bipush 42, iload_1, iadd
    load(8'h10, 8'h2A, 8'h1B, 8'h60);
    exp_q = '{32'hE3A0102A, 32'hE92D0002, 32'hE5913001, 32'hE92D0002,
              32'hE8BD0006, 32'hE0821001, 32'hE92D0002};
    run_prog("p2", 4, 1'b0, -1, 1'b0, 8'h0, 4, -1);
    run_prog("p2_stall", 4, 1'b1, -1, 1'b0, 8'h0, 4, -1);

    // iconst_0, unsupported 0xFF, iconst_1
    load(8'h03, 8'hFF, 8'h04, 8'h00);
    exp_q = '{32'hE3A01000, 32'hE92D0002};
    run_prog("p3_bad_op", 3, 1'b0, -1, 1'b1, 8'h01, 2, 3);

    // Empty program: done with no reads
    exp_q = '{};
    run_prog("len0", 0, 1'b0, -1, 1'b0, 8'h0, 0, -1);

    // bipush with missing operand
    load(8'h10, 8'h00, 8'h00, 8'h00);
    exp_q = '{};
    run_prog("bipush_short", 1, 1'b0, -1, 1'b1, 8'h00, 1, -1);

    // isub, then check error is cleared by the next start
    load(8'h64, 8'h00, 8'h00, 8'h00);
    exp_q = '{32'hE8BD0006, 32'hE0421001, 32'hE92D0002};
    run_prog("isub", 1, 1'b0, -1, 1'b0, 8'h0, 1, 3);

    // Reset while the second iadd word is presented, then replay
    load(8'h60, 8'h00, 8'h00, 8'h00);
    exp_q = '{32'hE8BD0006, 32'hE0821001, 32'hE92D0002};
    run_prog("iadd_reset", 1, 1'b0, 1, 1'b0, 8'h0, 1, -1);
    run_prog("iadd_replay", 1, 1'b0, -1, 1'b0, 8'h0, 1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
